bloco_datapath: RTL and testbench



---
 rtl/bloco_datapath_pkg.sv | 27 ++
 rtl/bloco_datapath_banco_registros.sv | 24 ++
 rtl/bloco_datapath.sv | 86 ++++++++
 tb/tb_bloco_datapath.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bloco_datapath_pkg.sv
// bloco_datapath_pkg: shared opcode enum, flag bit positions and default widths for the datapath
package bloco_datapath_pkg;
  localparam int BITS_PALAVRA_PADRAO = 16;
  localparam int END_REGISTROS_PADRAO = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_INC  = 5'b00010,
    OP_DEC  = 5'b00011,
    OP_AND  = 5'b00100,
    OP_OR   = 5'b00101,
    OP_XOR  = 5'b00110,
    OP_NOT  = 5'b00111,
    OP_PASA = 5'b01000,
    OP_PASB = 5'b01001,
    OP_SHL  = 5'b01010,
    OP_SHR  = 5'b01011,
    OP_SAR  = 5'b01100,
    OP_NEG  = 5'b01101,
    OP_ZERO = 5'b01110,
    OP_ONES = 5'b01111
  } opcode_t;
endpackage

// File: rtl/bloco_datapath_banco_registros.sv
// banco_registros: 2**end_registros x bits_palavra bank; ports clk, rst_n (async low clear), hab_escrita/sel_c/dado (sync write), sel_a/sel_b -> op_a/op_b (comb reads, old value on same-cycle write)
module banco_registros #(
  parameter int bits_palavra = 16,
  parameter int end_registros = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hab_escrita,
  input  logic [end_registros-1:0] sel_a,
  input  logic [end_registros-1:0] sel_b,
  input  logic [end_registros-1:0] sel_c,
  input  logic [bits_palavra-1:0]  dado,
  output logic [bits_palavra-1:0]  op_a,
  output logic [bits_palavra-1:0]  op_b
);
  logic [bits_palavra-1:0] regs [2**end_registros];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2**end_registros; i++) regs[i] <= '0;
    else if (hab_escrita)
      regs[sel_c] <= dado;
  assign op_a = regs[sel_a];
  assign op_b = regs[sel_b];
endmodule

// File: rtl/bloco_datapath.sv
// bloco_datapath: register bank + ALU + flag register; ports clk, reset_Ban_Registros/reset_Flags (async low), Hab_Escrita, Sel_SA/SB/SC, controleOperacao -> saida_ULA (comb), flags {Z,N,C,V} (registered)
module bloco_datapath
  import bloco_datapath_pkg::*;
#(
  parameter int bits_palavra = BITS_PALAVRA_PADRAO,
  parameter int end_registros = END_REGISTROS_PADRAO
) (
  input  logic                     clk,
  input  logic                     reset_Ban_Registros,
  input  logic                     reset_Flags,
  input  logic                     Hab_Escrita,
  input  logic [end_registros-1:0] Sel_SA,
  input  logic [end_registros-1:0] Sel_SB,
  input  logic [end_registros-1:0] Sel_SC,
  input  logic [4:0]               controleOperacao,
  output logic [bits_palavra-1:0]  saida_ULA,
  output logic [3:0]               flags
);
  localparam int M = bits_palavra - 1;
  localparam logic [bits_palavra:0] UM = 1;
  logic [M:0] a, b, res;
  logic c, v, valido;
  logic [3:0] prox_flags;
  banco_registros #(.bits_palavra(bits_palavra), .end_registros(end_registros)) u_banco (
    .clk(clk),
    .rst_n(reset_Ban_Registros),
    .hab_escrita(Hab_Escrita),
    .sel_a(Sel_SA),
    .sel_b(Sel_SB),
    .sel_c(Sel_SC),
    .dado(res),
    .op_a(a),
    .op_b(b)
  );
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    valido = ~controleOperacao[4];
    case (controleOperacao)
      OP_ADD: begin
        {c, res} = {1'b0, a} + {1'b0, b};
        v = (a[M] == b[M]) && (res[M] != a[M]);
      end
      OP_SUB: begin
        {c, res} = {1'b0, a} - {1'b0, b};
        v = (a[M] != b[M]) && (res[M] != a[M]);
      end
      OP_INC: begin
        {c, res} = {1'b0, a} + UM;
        v = ~a[M] & res[M];
      end
      OP_DEC: begin
        {c, res} = {1'b0, a} - UM;
        v = a[M] & ~res[M];
      end
      OP_AND: res = a & b;
      OP_OR: res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_PASA: res = a;
      OP_PASB: res = b;
      OP_SHL: {c, res} = {a, 1'b0};
      OP_SHR: {res, c} = {1'b0, a};
      OP_SAR: {res, c} = {a[M], a};
      OP_NEG: begin
        {c, res} = {(bits_palavra+1){1'b0}} - {1'b0, a};
        v = a[M] & res[M];
      end
      OP_ZERO: res = '0;
      OP_ONES: res = '1;
      default: ;
    endcase
  end
  always_comb begin
    prox_flags = '0;
    prox_flags[FLAG_Z] = res == '0;
    prox_flags[FLAG_N] = res[M];
    prox_flags[FLAG_C] = c;
    prox_flags[FLAG_V] = v;
  end
  assign saida_ULA = res;
  always_ff @(posedge clk or negedge reset_Flags)
    if (!reset_Flags) flags <= '0;
    else if (Hab_Escrita && valido) flags <= prox_flags;
endmodule

// File: tb/tb_bloco_datapath.sv
// tb_bloco_datapath: directed vectors with a behavioural model and literal spot checks
module tb_bloco_datapath;
  logic clk = 0, rb = 0, rf = 0, we = 0;
  logic [1:0] sa = 0, sb = 0, sc = 0;
  logic [4:0] op = 0;
  logic [15:0] saida_ULA;
  logic [3:0] flags;
  int errors = 0, checks = 0;
  int mregs [4] = '{0, 0, 0, 0};
  logic [3:0] mflags = 0;
  bit run = 0;

  bloco_datapath dut (
    .clk(clk), .reset_Ban_Registros(rb), .reset_Flags(rf), .Hab_Escrita(we),
    .Sel_SA(sa), .Sel_SB(sb), .Sel_SC(sc), .controleOperacao(op),
    .saida_ULA(saida_ULA), .flags(flags)
  );

  always #5 clk = ~clk;

  function automatic bit ovf(input int x);
    return x > 32767 || x < -32768;
  endfunction

  function automatic void model(input logic [4:0] o, input int a, input int b,
                                output int r, output logic [3:0] f, output bit ok);
    int sa_i, sb_i;
    bit c, v;
    logic [15:0] la, lb;
    la = 16'(a);
    lb = 16'(b);
    sa_i = a >= 32768 ? a - 65536 : a;
    sb_i = b >= 32768 ? b - 65536 : b;
    c = 0;
    v = 0;
    r = 0;
    ok = o < 16;
    case (o)
      0: begin r = (a + b) % 65536; c = a + b > 65535; v = ovf(sa_i + sb_i); end
      1: begin r = (a - b + 65536) % 65536; c = a < b; v = ovf(sa_i - sb_i); end
      2: begin r = (a + 1) % 65536; c = a == 65535; v = ovf(sa_i + 1); end
      3: begin r = (a + 65535) % 65536; c = a == 0; v = ovf(sa_i - 1); end
      4: r = int'(la & lb);
      5: r = int'(la | lb);
      6: r = int'(la ^ lb);
      7: r = 65535 - a;
      8: r = a;
      9: r = b;
      10: begin r = (a * 2) % 65536; c = a >= 32768; end
      11: begin r = a / 2; c = a % 2 == 1; end
      12: begin r = a / 2 + (a >= 32768 ? 32768 : 0); c = a % 2 == 1; end
      13: begin r = (65536 - a) % 65536; c = a != 0; v = ovf(-sa_i); end
      14: r = 0;
      15: r = 65535;
      default: r = 0;
    endcase
    f = {r == 0, r >= 32768, c, v};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int r;
    logic [3:0] f;
    bit ok;
    model(op, mregs[sa], mregs[sb], r, f, ok);
    if (rb && we) mregs[sc] = r;
    if (rf && we && ok) mflags = f;
  end
  always @(negedge rb) mregs = '{0, 0, 0, 0};
  always @(negedge rf) mflags = 0;

  always @(negedge clk) if (run) begin
    int r;
    logic [3:0] f;
    bit ok;
    model(op, mregs[sa], mregs[sb], r, f, ok);
    chk("model_alu", saida_ULA, 16'(r));
    chk("model_flags", {12'd0, flags}, {12'd0, mflags});
  end

  task automatic set(input logic w, input logic [1:0] a, input logic [1:0] b,
                     input logic [1:0] c, input logic [4:0] o);
    we = w; sa = a; sb = b; sc = c; op = o;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string nm, input logic [1:0] k, input logic [15:0] exp);
    set(0, k, k, 0, 5'b01000);
    #1 chk(nm, saida_ULA, exp);
  endtask

  initial begin
    #2;
    chk("reset_alu", saida_ULA, 16'h0000);
    chk("reset_flags", {12'd0, flags}, 16'h0000);
    rb = 1; rf = 1; run = 1;
    set(1, 1, 1, 0, 5'b00000);
    #1 chk("add_zero_alu", saida_ULA, 16'h0000);
    edge1();
    chk("add_zero_flags", {12'd0, flags}, 16'h0008);
    rd("r0_zero", 0, 16'h0000);
    edge1();
    set(1, 0, 0, 1, 5'b01111); edge1();
    set(1, 1, 0, 2, 5'b00010); edge1();
    chk("inc_carry_flags", {12'd0, flags}, 16'h000A);
    rd("r2_wrap", 2, 16'h0000);
    edge1();
    set(1, 1, 0, 1, 5'b01011); edge1();
    chk("shr_flags", {12'd0, flags}, 16'h0002);
    set(1, 1, 0, 3, 5'b00010); edge1();
    chk("inc_ovf_flags", {12'd0, flags}, 16'h0005);
    rd("r3_8000", 3, 16'h8000);
    edge1();
    set(1, 0, 0, 0, 5'b01110); edge1();
    set(1, 0, 0, 1, 5'b01111); edge1();
    set(1, 0, 1, 2, 5'b00001);
    #1 chk("sub_borrow_alu", saida_ULA, 16'h0001);
    edge1();
    chk("sub_borrow_flags", {12'd0, flags}, 16'h0002);
    set(1, 1, 1, 3, 5'b00001);
    #1 chk("sub_self_alu", saida_ULA, 16'h0000);
    edge1();
    chk("sub_self_flags", {12'd0, flags}, 16'h0008);
    set(0, 1, 1, 1, 5'b00000);
    #1 chk("inhibit_alu", saida_ULA, 16'hFFFE);
    edge1(); edge1();
    chk("inhibit_flags", {12'd0, flags}, 16'h0008);
    rd("inhibit_r1", 1, 16'hFFFF);
    edge1();
    set(1, 1, 1, 2, 5'b10000);
    #1 chk("reserved_alu", saida_ULA, 16'h0000);
    edge1();
    chk("reserved_flags", {12'd0, flags}, 16'h0008);
    rd("reserved_r2", 2, 16'h0000);
    edge1();
    set(1, 0, 0, 3, 5'b01111); edge1();
    chk("ones_flags", {12'd0, flags}, 16'h0004);
    rd("pre_rb_r1", 1, 16'hFFFF);
    rb = 0;
    #1 rd("rb_r1", 1, 16'h0000);
    chk("rb_keeps_flags", {12'd0, flags}, 16'h0004);
    rb = 1;
    edge1();
    set(1, 0, 0, 1, 5'b01111); edge1();
    rd("rebuild_r1", 1, 16'hFFFF);
    rf = 0;
    #1 chk("rf_flags", {12'd0, flags}, 16'h0000);
    rd("rf_keeps_r1", 1, 16'hFFFF);
    rf = 1;
    edge1();
    set(1, 0, 0, 2, 5'b01111);
    rb = 0;
    edge1();
    rb = 1;
    rd("suppressed_r2", 2, 16'h0000);
    chk("flags_indep", {12'd0, flags}, 16'h0004);
    edge1();
    set(1, 0, 0, 2, 5'b01111); edge1();
    rd("resume_r2", 2, 16'hFFFF);
    edge1();
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
